// File: rtl/dmem_req_ctrl_pkg.sv
// Shared types for the data-memory request controller.
// Request bundle, controller state and address helper.
package dmem_req_ctrl_pkg;

    typedef logic [31:0] word32_t;

    // Widest tag a request entry can carry; TAG_W must not exceed it.
    localparam int TAG_MAX_W = 8;

    typedef enum logic {
        IDLE,
        BUSY
    } dmem_ctrl_state_e;

    typedef struct packed {
        logic                 is_store;
        logic                 kill;
        word32_t              addr;
        word32_t              data;
        logic [TAG_MAX_W-1:0] tag;
    } dmem_req_t;

    function automatic word32_t word_align(input word32_t a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/dmem_req_ctrl_if.sv
// Core-side dmem port: strobes, address and data out, read data and done back.
// The controller is the master, the memory the slave.
interface dmem_req_ctrl_if;
    import dmem_req_ctrl_pkg::*;

    logic    dmem_read;
    logic    dmem_write;
    word32_t dmem_addr;
    word32_t dmem_data;
    word32_t dmem_rd_data;
    logic    dmem_done;

    modport master (
        output dmem_read, dmem_write, dmem_addr, dmem_data,
        input  dmem_rd_data, dmem_done
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_addr, dmem_data,
        output dmem_rd_data, dmem_done
    );

endinterface

// File: rtl/dmem_req_ctrl_fifo.sv
// In-order request queue; each entry's kill bit can be set in place.
// A push to a slot overrides a kill-set aimed at the same slot.
module sync_fifo
    import dmem_req_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  dmem_req_t        wdata_i,
    input  logic             pop_i,
    input  logic [DEPTH-1:0] kill_set_i,
    output dmem_req_t        head_o,
    output logic [DEPTH-1:0] ld_mask_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    dmem_req_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);

    always_comb begin
        ld_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_mask_o[i] = ~mem_q[i].is_store;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_set_i[i]) begin
                    mem_q[i].kill <= 1'b1;
                end
            end
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: queues LSU requests, runs one blocking
// dmem transaction at a time and returns tagged load data.
module dmem_req_ctrl
    import dmem_req_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_is_store_i,
    input  word32_t           req_addr_i,
    input  word32_t           req_data_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    input  logic              flush_i,
    dmem_req_ctrl_if.master   dmem,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [TAG_W-1:0]  resp_tag_o,
    output word32_t           resp_data_o
);

    dmem_ctrl_state_e     state_q;
    logic                 rst_done_q;
    logic                 rd_q, wr_q, live_q;
    word32_t              addr_q, data_q;
    logic [TAG_MAX_W-1:0] tag_q;
    logic                 resp_valid_q;
    logic [TAG_MAX_W-1:0] resp_tag_q;
    word32_t              resp_data_q;

    dmem_req_t        wdata, head, cand;
    logic [DEPTH-1:0] ld_mask, kill_set;
    logic             empty, full, push, q_push, q_pop;
    logic             cand_kill, take, issue;
    logic             unused_tag;

    assign req_ready_o = rst_done_q & ~full;
    assign push        = req_valid_i & req_ready_o;

    always_comb begin
        wdata          = '0;
        wdata.is_store = req_is_store_i;
        wdata.kill     = flush_i & ~req_is_store_i;
        wdata.addr     = req_addr_i;
        wdata.data     = req_data_i;
        wdata.tag      = TAG_MAX_W'(req_tag_i);
    end

    // An empty queue lets the incoming request issue in its accept cycle.
    assign cand      = empty ? wdata : head;
    assign cand_kill = cand.kill | (flush_i & ~cand.is_store);

    always_comb begin
        take  = 1'b0;
        issue = 1'b0;
        if (state_q == IDLE && (!empty || push)) begin
            unique case (1'b1)
                cand.is_store: begin
                    take  = 1'b1;
                    issue = 1'b1;
                end
                cand_kill: take = 1'b1;
                default: begin
                    take  = ~resp_valid_q;
                    issue = ~resp_valid_q;
                end
            endcase
        end
    end

    assign q_pop    = take & ~empty;
    assign q_push   = push & ~(empty & take);
    assign kill_set = flush_i ? ld_mask : '0;

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .push_i     (q_push),
        .wdata_i    (wdata),
        .pop_i      (q_pop),
        .kill_set_i (kill_set),
        .head_o     (head),
        .ld_mask_o  (ld_mask),
        .empty_o    (empty),
        .full_o     (full)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            rst_done_q   <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            live_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            tag_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            rst_done_q <= 1'b1;
            if (resp_valid_q && resp_ready_i) begin
                resp_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= BUSY;
                        rd_q    <= ~cand.is_store;
                        wr_q    <= cand.is_store;
                        live_q  <= ~cand.is_store;
                        addr_q  <= word_align(cand.addr);
                        data_q  <= cand.data;
                        tag_q   <= cand.tag;
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        live_q <= 1'b0;
                    end
                    if (dmem.dmem_done) begin
                        state_q <= IDLE;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        live_q  <= 1'b0;
                        if (live_q && !flush_i) begin
                            resp_valid_q <= 1'b1;
                            resp_tag_q   <= tag_q;
                            resp_data_q  <= dmem.dmem_rd_data;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A flush drops any response the consumer has not taken yet.
            if (flush_i) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    assign dmem.dmem_read  = rd_q;
    assign dmem.dmem_write = wr_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_data  = data_q;

    assign resp_valid_o = resp_valid_q;
    assign resp_tag_o   = resp_tag_q[TAG_W-1:0];
    assign resp_data_o  = resp_data_q;
    assign unused_tag   = ^resp_tag_q;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl against a fixed-latency dmem model.
// Unwritten memory words read back as 0xA500_0000 | word index.
module tb_dmem_req_ctrl;
    import dmem_req_ctrl_pkg::*;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_is_store = 1'b0;
    word32_t    req_addr = '0;
    word32_t    req_data = '0;
    logic [4:0] req_tag = '0;
    logic       flush = 1'b0;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic [4:0] resp_tag;
    word32_t    resp_data;
    logic       stall = 1'b0;

    dmem_req_ctrl_if dif ();

    dmem_req_ctrl #(.DEPTH(4), .TAG_W(5)) dut (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_is_store_i (req_is_store),
        .req_addr_i     (req_addr),
        .req_data_i     (req_data),
        .req_tag_i      (req_tag),
        .flush_i        (flush),
        .dmem           (dif),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_tag_o     (resp_tag),
        .resp_data_o    (resp_data)
    );

    always #5 clk = ~clk;

    word32_t      mem [256];
    logic [255:0] wv;
    int           cnt, n_rd, n_wr, n_resp;
    logic [4:0]   rtag_q [$];
    word32_t      rdata_q [$];
    int           n_tests = 0;
    int           n_fail = 0;

    function automatic word32_t mrd(input logic [7:0] idx);
        return wv[idx] ? mem[idx] : (32'hA500_0000 | {24'h0, idx});
    endfunction

    // dmem model: done pulses LAT cycles after the strobe rises.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt               <= 0;
            n_rd              <= 0;
            n_wr              <= 0;
            wv                <= '0;
            dif.dmem_done     <= 1'b0;
            dif.dmem_rd_data  <= '0;
        end else begin
            dif.dmem_done <= 1'b0;
            if ((dif.dmem_read || dif.dmem_write) && !dif.dmem_done && !stall) begin
                if (cnt == LAT - 1) begin
                    cnt           <= 0;
                    dif.dmem_done <= 1'b1;
                    if (dif.dmem_write) begin
                        mem[dif.dmem_addr[9:2]] <= dif.dmem_data;
                        wv[dif.dmem_addr[9:2]]  <= 1'b1;
                        n_wr                    <= n_wr + 1;
                    end else begin
                        dif.dmem_rd_data <= mrd(dif.dmem_addr[9:2]);
                        n_rd             <= n_rd + 1;
                    end
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_resp <= 0;
        end else if (resp_valid && resp_ready) begin
            n_resp <= n_resp + 1;
            rtag_q.push_back(resp_tag);
            rdata_q.push_back(resp_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return dif.dmem_read;
            1:       return dif.dmem_write;
            2:       return dif.dmem_done;
            3:       return resp_valid;
            default: return req_ready;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int which, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (sig(which) === 1'b1) break;
            cyc(1);
        end
        chk(tag, 32'(sig(which)), 32'd1);
    endtask

    task automatic set_req(input logic st, input word32_t a, input word32_t d,
                           input logic [4:0] t);
        req_valid    = 1'b1;
        req_is_store = st;
        req_addr     = a;
        req_data     = d;
        req_tag      = t;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, rd0, wr0;

        // Reset state
        cyc(2);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_read", 32'(dif.dmem_read), 0);
        chk("rst_write", 32'(dif.dmem_write), 0);
        chk("rst_resp", 32'(resp_valid), 0);
        rst_n = 1'b1;
        cyc(1);
        chk("ready_after_rst", 32'(req_ready), 1);

        // Store then misaligned load of the same word
        set_req(1'b1, 32'h100, 32'hDEAD_BEEF, 5'd0);
        cyc(1);
        chk("st_write", 32'(dif.dmem_write), 1);
        chk("st_read", 32'(dif.dmem_read), 0);
        chk("st_addr", dif.dmem_addr, 32'h100);
        chk("st_data", dif.dmem_data, 32'hDEAD_BEEF);
        set_req(1'b0, 32'h103, 32'h0, 5'd3);
        cyc(1);
        req_valid = 1'b0;
        wait_sig("ld_read_wait", 0, 20);
        chk("ld_after_store", 32'(n_wr), 1);
        chk("ld_addr_align", dif.dmem_addr, 32'h100);
        wait_sig("ld_done_wait", 2, 20);
        cyc(1);
        chk("ld_resp_valid", 32'(resp_valid), 1);
        chk("ld_strobe_low", 32'(dif.dmem_read), 0);
        chk("ld_resp_tag", 32'(resp_tag), 3);
        chk("ld_resp_data", resp_data, 32'hDEAD_BEEF);
        cyc(1);
        chk("ld_resp_taken", 32'(resp_valid), 0);
        chk("ld_nresp", 32'(n_resp), 1);

        // One load in flight plus four queued fills the queue
        base  = n_resp;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b0, 32'h200 + 32'(4 * i), 32'h0, 5'(20 + i));
            cyc(1);
            if (i == 3) chk("fill_ready_3q", 32'(req_ready), 1);
        end
        chk("fill_full", 32'(req_ready), 0);
        set_req(1'b0, 32'h214, 32'h0, 5'd25);
        cyc(3);
        chk("fill_held", 32'(req_ready), 0);
        chk("fill_head_addr", dif.dmem_addr, 32'h200);
        stall = 1'b0;
        wait_sig("fill_ready_again", 4, 40);
        cyc(1);
        req_valid = 1'b0;
        for (int i = 0; i < 200 && n_resp < base + 6; i++) cyc(1);
        chk("fill_nresp", 32'(n_resp), 32'(base + 6));
        for (int k = 0; k < 6 && base + k < rtag_q.size(); k++) begin
            chk("fill_tag", 32'(rtag_q[base + k]), 32'(20 + k));
            chk("fill_data", rdata_q[base + k], 32'hA500_0080 + 32'(k));
        end

        // Flush with one load in flight and two queued
        base  = n_resp;
        stall = 1'b1;
        set_req(1'b0, 32'h300, 32'h0, 5'd7);
        cyc(1);
        set_req(1'b0, 32'h304, 32'h0, 5'd8);
        cyc(1);
        set_req(1'b0, 32'h308, 32'h0, 5'd9);
        cyc(1);
        req_valid = 1'b0;
        cyc(1);
        chk("fl_busy_read", 32'(dif.dmem_read), 1);
        chk("fl_busy_addr", dif.dmem_addr, 32'h300);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        rd0   = n_rd;
        stall = 1'b0;
        wait_sig("fl_done_wait", 2, 20);
        cyc(1);
        chk("fl_no_resp", 32'(resp_valid), 0);
        chk("fl_n1_read", 32'(dif.dmem_read), 0);
        chk("fl_n1_nonempty", 32'(dut.u_fifo.empty_o), 0);
        cyc(1);
        chk("fl_n2_read", 32'(dif.dmem_read), 0);
        chk("fl_n2_nonempty", 32'(dut.u_fifo.empty_o), 0);
        cyc(1);
        chk("fl_n3_read", 32'(dif.dmem_read), 0);
        chk("fl_n3_empty", 32'(dut.u_fifo.empty_o), 1);
        cyc(8);
        chk("fl_one_read", 32'(n_rd), 32'(rd0 + 1));
        chk("fl_zero_resp", 32'(n_resp), 32'(base));

        // Response held while a queued store goes ahead
        base       = n_resp;
        resp_ready = 1'b0;
        set_req(1'b0, 32'h100, 32'h0, 5'd11);
        cyc(1);
        set_req(1'b1, 32'h180, 32'h1234_5678, 5'd0);
        cyc(1);
        set_req(1'b0, 32'h180, 32'h0, 5'd12);
        cyc(1);
        req_valid = 1'b0;
        wait_sig("hold_resp_wait", 3, 30);
        wr0 = n_wr;
        rd0 = n_rd;
        for (int k = 0; k < 10; k++) begin
            chk("hold_valid", 32'(resp_valid), 1);
            chk("hold_tag", 32'(resp_tag), 11);
            chk("hold_data", resp_data, 32'hDEAD_BEEF);
            cyc(1);
        end
        chk("hold_store_went", 32'(n_wr), 32'(wr0 + 1));
        chk("hold_load_waits", 32'(n_rd), 32'(rd0));
        chk("hold_no_read", 32'(dif.dmem_read), 0);
        resp_ready = 1'b1;
        for (int i = 0; i < 40 && n_resp < base + 2; i++) cyc(1);
        chk("hold_nresp", 32'(n_resp), 32'(base + 2));
        if (rtag_q.size() >= base + 2) begin
            chk("hold_tag0", 32'(rtag_q[base]), 11);
            chk("hold_data0", rdata_q[base], 32'hDEAD_BEEF);
            chk("hold_tag1", 32'(rtag_q[base + 1]), 12);
            chk("hold_data1", rdata_q[base + 1], 32'h1234_5678);
        end

        // Reset in the middle of a transaction
        stall = 1'b1;
        set_req(1'b0, 32'h104, 32'h0, 5'd5);
        cyc(1);
        set_req(1'b0, 32'h108, 32'h0, 5'd6);
        cyc(1);
        req_valid = 1'b0;
        cyc(2);
        chk("mid_read", 32'(dif.dmem_read), 1);
        chk("mid_queued", 32'(dut.u_fifo.empty_o), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_read", 32'(dif.dmem_read), 0);
        chk("arst_write", 32'(dif.dmem_write), 0);
        chk("arst_ready", 32'(req_ready), 0);
        chk("arst_resp", 32'(resp_valid), 0);
        chk("arst_empty", 32'(dut.u_fifo.empty_o), 1);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        cyc(12);
        chk("post_rst_nresp", 32'(n_resp), 0);
        chk("post_rst_nrd", 32'(n_rd), 0);
        chk("post_rst_read", 32'(dif.dmem_read), 0);
        chk("post_rst_ready", 32'(req_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
